// File: rtl/sprite_motion_ctrl_if.sv
// Button inputs and sprite position outputs of sprite_motion_ctrl.
// The master drives the raw buttons and speed select; the slave reports position, run state and step pulses.
interface sprite_motion_ctrl_if;
    logic       btnC;
    logic       btnU;
    logic       btnD;
    logic       btnL;
    logic       btnR;
    logic       speed_sel;
    logic [6:0] pos_x;
    logic [5:0] pos_y;
    logic       active;
    logic       step;

    modport master (
        output btnC, btnU, btnD, btnL, btnR, speed_sel,
        input  pos_x, pos_y, active, step
    );

    modport slave (
        input  btnC, btnU, btnD, btnL, btnR, speed_sel,
        output pos_x, pos_y, active, step
    );
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Debounces the five push buttons, runs the start/home FSM and steps the sprite position at a selectable repeat rate.
// Define SPRITE_WRAP_EN to wrap the sprite to the opposite edge instead of clamping it.
module sprite_motion_ctrl #(
    parameter int DEB_CYCLES  = 100000,
    parameter int PERIOD_NORM = 2222000,
    parameter int PERIOD_SLOW = 3333000,
    parameter int SIZE        = 6,
    parameter int X_MAX       = 95,
    parameter int Y_MAX       = 63,
    parameter int HOME_X      = 45,
    parameter int HOME_Y      = 55
) (
    input logic            CLOCK,
    input logic            RESET_N,
    sprite_motion_ctrl_if.slave bus
);
    localparam int NB     = 5;
    localparam int B_R    = 0;
    localparam int B_L    = 1;
    localparam int B_D    = 2;
    localparam int B_U    = 3;
    localparam int B_C    = 4;
    localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int PMAX   = (PERIOD_NORM > PERIOD_SLOW) ? PERIOD_NORM : PERIOD_SLOW;
    localparam int RATE_W = (PMAX > 1) ? $clog2(PMAX) : 1;

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [RATE_W-1:0] NORM_LAST = RATE_W'(PERIOD_NORM - 1);
    localparam logic [RATE_W-1:0] SLOW_LAST = RATE_W'(PERIOD_SLOW - 1);
    localparam logic [7:0]        X_LIM     = 8'(X_MAX - SIZE + 1);
    localparam logic [7:0]        Y_LIM     = 8'(Y_MAX - SIZE + 1);
    localparam logic [6:0]        HOME_X_V  = 7'(HOME_X);
    localparam logic [5:0]        HOME_Y_V  = 6'(HOME_Y);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        DIR_NONE = 3'd0,
        DIR_L    = 3'd1,
        DIR_R    = 3'd2,
        DIR_U    = 3'd3,
        DIR_D    = 3'd4
    } dir_t;

    // One axis step in 8 bits; returns {taken, new value}. Out-of-range results never wrap silently.
    function automatic logic [8:0] axis_step(input logic [7:0] cur, input logic inc, input logic [7:0] lim);
        logic [7:0] nxt;
        nxt = inc ? (cur + 8'd1) : (cur - 8'd1);
        if (nxt <= lim) begin
            axis_step = {1'b1, nxt};
        end else begin
`ifdef SPRITE_WRAP_EN
            axis_step = {1'b1, (inc ? 8'd0 : lim)};
`else
            axis_step = {1'b0, cur};
`endif
        end
    endfunction

    logic [NB-1:0]     raw_s;
    logic [NB-1:0]     sync1_r;
    logic [NB-1:0]     sync2_r;
    logic [NB-1:0]     deb_r;
    logic [DEB_W-1:0]  deb_cnt_r [NB];
    logic              c_prev_r;
    logic              c_rise_s;

    state_t            state_r;
    state_t            state_next_s;
    dir_t              dir_r;
    dir_t              dir_s;
    logic [RATE_W-1:0] rate_r;
    logic [RATE_W-1:0] rate_next_s;
    logic [RATE_W-1:0] period_last_s;
    logic              move_req_s;
    logic [8:0]        mv_x_s;
    logic [8:0]        mv_y_s;

    logic [6:0]        pos_x_r;
    logic [6:0]        pos_x_next_s;
    logic [5:0]        pos_y_r;
    logic [5:0]        pos_y_next_s;
    logic              step_r;
    logic              step_next_s;
    logic              active_r;
    logic              active_next_s;

    assign raw_s         = {bus.btnC, bus.btnU, bus.btnD, bus.btnL, bus.btnR};
    assign c_rise_s      = deb_r[B_C] & ~c_prev_r;
    assign period_last_s = bus.speed_sel ? SLOW_LAST : NORM_LAST;
    assign mv_x_s        = axis_step({1'b0, pos_x_r}, (dir_s == DIR_L), X_LIM);
    assign mv_y_s        = axis_step({2'b00, pos_y_r}, (dir_s == DIR_U), Y_LIM);

    // Synchronise each raw button and flip its debounced level after DEB_CYCLES stable cycles.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_r  <= '0;
            sync2_r  <= '0;
            deb_r    <= '0;
            c_prev_r <= 1'b0;
            for (int i = 0; i < NB; i++) begin
                deb_cnt_r[i] <= '0;
            end
        end else begin
            sync1_r  <= raw_s;
            sync2_r  <= sync1_r;
            c_prev_r <= deb_r[B_C];
            for (int i = 0; i < NB; i++) begin
                if (sync2_r[i] != deb_r[i]) begin
                    if (deb_cnt_r[i] == DEB_LAST) begin
                        deb_r[i]     <= ~deb_r[i];
                        deb_cnt_r[i] <= '0;
                    end else begin
                        deb_cnt_r[i] <= deb_cnt_r[i] + DEB_W'(1);
                    end
                end else begin
                    deb_cnt_r[i] <= '0;
                end
            end
        end
    end

    // Direction priority L > R > U > D, serviced only while running.
    always_comb begin
        dir_s = DIR_NONE;
        if (state_r == ST_RUN) begin
            if (deb_r[B_L]) begin
                dir_s = DIR_L;
            end else if (deb_r[B_R]) begin
                dir_s = DIR_R;
            end else if (deb_r[B_U]) begin
                dir_s = DIR_U;
            end else if (deb_r[B_D]) begin
                dir_s = DIR_D;
            end else begin
                dir_s = DIR_NONE;
            end
        end else begin
            dir_s = DIR_NONE;
        end
    end

    // Repeat timer: immediate step on a new direction, then one step per period; the period is re-sampled every cycle.
    always_comb begin
        rate_next_s = rate_r;
        move_req_s  = 1'b0;
        if (dir_s == DIR_NONE) begin
            rate_next_s = '0;
        end else if (dir_s != dir_r) begin
            move_req_s  = 1'b1;
            rate_next_s = '0;
        end else if (rate_r >= period_last_s) begin
            move_req_s  = 1'b1;
            rate_next_s = '0;
        end else begin
            rate_next_s = rate_r + RATE_W'(1);
        end
    end

    // FSM next state and position update; a home reload overrides any step in the same cycle.
    always_comb begin
        state_next_s  = state_r;
        pos_x_next_s  = pos_x_r;
        pos_y_next_s  = pos_y_r;
        step_next_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (c_rise_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                state_next_s = ST_RUN;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        active_next_s = (state_next_s == ST_RUN);

        if (c_rise_s) begin
            pos_x_next_s = HOME_X_V;
            pos_y_next_s = HOME_Y_V;
        end else if (move_req_s && ((dir_s == DIR_L) || (dir_s == DIR_R)) && mv_x_s[8]) begin
            pos_x_next_s = 7'(mv_x_s);
            step_next_s  = 1'b1;
        end else if (move_req_s && ((dir_s == DIR_U) || (dir_s == DIR_D)) && mv_y_s[8]) begin
            pos_y_next_s = 6'(mv_y_s);
            step_next_s  = 1'b1;
        end else begin
            step_next_s  = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Registered position, outputs and repeat-timer state.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            pos_x_r  <= HOME_X_V;
            pos_y_r  <= HOME_Y_V;
            step_r   <= 1'b0;
            active_r <= 1'b0;
            rate_r   <= '0;
            dir_r    <= DIR_NONE;
        end else begin
            pos_x_r  <= pos_x_next_s;
            pos_y_r  <= pos_y_next_s;
            step_r   <= step_next_s;
            active_r <= active_next_s;
            rate_r   <= rate_next_s;
            dir_r    <= dir_s;
        end
    end

    assign bus.pos_x  = pos_x_r;
    assign bus.pos_y  = pos_y_r;
    assign bus.active = active_r;
    assign bus.step   = step_r;
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Self-checking bench for sprite_motion_ctrl: expected step events (position and cycle) are queued as stimulus
// is applied and compared by a monitor whenever the design pulses step.
module tb_sprite_motion_ctrl;
    localparam int DEB = 4;
    localparam int PN  = 10;
    localparam int PS  = 20;
    localparam int XL  = 90;
    localparam int YL  = 58;
    localparam int HX  = 45;
    localparam int HY  = 55;

    typedef struct {
        int x;
        int y;
        int c;
    } ev_t;

    logic CLOCK   = 1'b0;
    logic RESET_N = 1'b0;
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;
    int   ex_x    = HX;
    int   ex_y    = HY;
    ev_t  exp_q[$];

    sprite_motion_ctrl_if bus ();

    sprite_motion_ctrl #(
        .DEB_CYCLES (DEB),
        .PERIOD_NORM(PN),
        .PERIOD_SLOW(PS)
    ) dut (
        .CLOCK  (CLOCK),
        .RESET_N(RESET_N),
        .bus    (bus)
    );

    always #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) cyc <= cyc + 1;

    // Scoreboard monitor: every step pulse must match the oldest queued expectation.
    always @(negedge CLOCK) begin
        ev_t e;
        if (bus.step === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL step_unexpected: got step at cycle %0d pos (%0d,%0d), required no step", cyc, bus.pos_x, bus.pos_y);
            end else begin
                e = exp_q.pop_front();
                if (bus.pos_x !== 7'(e.x) || bus.pos_y !== 6'(e.y) || cyc != e.c) begin
                    errors++;
                    $display("FAIL step_event: got (%0d,%0d) at cycle %0d, required (%0d,%0d) at cycle %0d",
                             bus.pos_x, bus.pos_y, cyc, e.x, e.y, e.c);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    function automatic void push_ev(input int x, input int y, input int c);
        ev_t e;
        e.x = x;
        e.y = y;
        e.c = c;
        exp_q.push_back(e);
    endfunction

    function automatic int mnext(input int v, input int d, input int lim);
        int n;
        n = v + d;
        if (n >= 0 && n <= lim) return n;
`ifdef SPRITE_WRAP_EN
        return (d > 0) ? 0 : lim;
`else
        return -1;
`endif
    endfunction

    task automatic test_reset();
        bus.btnC = 1'b0; bus.btnU = 1'b0; bus.btnD = 1'b0;
        bus.btnL = 1'b0; bus.btnR = 1'b0; bus.speed_sel = 1'b0;
        RESET_N = 1'b0;
        tick(3);
        checks++;
        if (bus.active !== 1'b0 || bus.pos_x !== 7'd45 || bus.pos_y !== 6'd55 || bus.step !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got active=%0b pos=(%0d,%0d) step=%0b, required 0 (45,55) 0",
                     bus.active, bus.pos_x, bus.pos_y, bus.step);
        end
        RESET_N = 1'b1;
        tick(2);
        bus.btnL = 1'b1;
        tick(50);
        checks++;
        if (bus.active !== 1'b0 || bus.pos_x !== 7'd45 || bus.pos_y !== 6'd55) begin
            errors++;
            $display("FAIL idle_ignores_dir: got active=%0b pos=(%0d,%0d), required 0 (45,55)",
                     bus.active, bus.pos_x, bus.pos_y);
        end
        bus.btnL = 1'b0;
        tick(12);
    endtask

    task automatic test_start_and_left();
        int seen;
        int c1;
        seen = -1;
        bus.btnC = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            if (bus.active === 1'b1 && seen < 0) seen = k;
        end
        checks++;
        if (seen < 1) begin
            errors++;
            $display("FAIL start_active: got active=%0b after 7 cycles, required 1", bus.active);
        end
        checks++;
        if (bus.pos_x !== 7'd45 || bus.pos_y !== 6'd55) begin
            errors++;
            $display("FAIL start_home: got (%0d,%0d), required (45,55)", bus.pos_x, bus.pos_y);
        end
        tick(3);
        bus.btnC = 1'b0;
        tick(12);
        bus.speed_sel = 1'b0;
        c1 = cyc;
        for (int k = 0; k < 5; k++) begin
            ex_x = mnext(ex_x, 1, XL);
            push_ev(ex_x, ex_y, c1 + 7 + PN * k);
        end
        bus.btnL = 1'b1;
        tick(46);
        bus.btnL = 1'b0;
        tick(16);
        checks++;
        if (exp_q.size() != 0 || bus.pos_x !== 7'd50) begin
            errors++;
            $display("FAIL left_repeat: got pos_x=%0d with %0d steps missing, required 50 with 0", bus.pos_x, exp_q.size());
        end
    endtask

    task automatic test_clamp_down();
        int c2;
        int ny;
        bus.speed_sel = 1'b1;
        c2 = cyc;
        for (int k = 0; k <= 56; k++) begin
            ny = mnext(ex_y, -1, YL);
            if (ny >= 0) begin
                ex_y = ny;
                push_ev(ex_x, ex_y, c2 + 7 + PS * k);
            end
        end
        bus.btnD = 1'b1;
        tick(1130);
        bus.btnD = 1'b0;
        tick(12);
        bus.speed_sel = 1'b0;
        checks++;
        if (exp_q.size() != 0 || bus.pos_y !== 6'(ex_y)) begin
            errors++;
            $display("FAIL down_clamp: got pos_y=%0d with %0d steps missing, required %0d with 0", bus.pos_y, exp_q.size(), ex_y);
        end
    endtask

    task automatic test_priority();
        int c3;
        c3 = cyc;
        for (int k = 0; k < 3; k++) begin
            ex_x = mnext(ex_x, 1, XL);
            push_ev(ex_x, ex_y, c3 + 7 + PN * k);
        end
        for (int k = 0; k < 3; k++) begin
            ex_y = mnext(ex_y, 1, YL);
            push_ev(ex_x, ex_y, c3 + 37 + PN * k);
        end
        bus.btnL = 1'b1;
        bus.btnU = 1'b1;
        tick(30);
        bus.btnL = 1'b0;
        tick(30);
        bus.btnU = 1'b0;
        tick(12);
        checks++;
        if (exp_q.size() != 0 || bus.pos_x !== 7'(ex_x) || bus.pos_y !== 6'(ex_y)) begin
            errors++;
            $display("FAIL priority_lu: got (%0d,%0d) with %0d steps missing, required (%0d,%0d) with 0",
                     bus.pos_x, bus.pos_y, exp_q.size(), ex_x, ex_y);
        end
    endtask

    task automatic test_bounce();
        int cl;
        for (int i = 0; i < 6; i++) begin
            bus.btnR = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick(2);
        end
        bus.btnR = 1'b1;
        cl = cyc;
        ex_x = mnext(ex_x, -1, XL);
        push_ev(ex_x, ex_y, cl + 7);
        tick(8);
        bus.btnR = 1'b0;
        tick(16);
        checks++;
        if (exp_q.size() != 0 || bus.pos_x !== 7'(ex_x)) begin
            errors++;
            $display("FAIL right_bounce: got pos_x=%0d with %0d steps missing, required %0d with 0", bus.pos_x, exp_q.size(), ex_x);
        end
    endtask

    task automatic test_home_and_reset();
        int c5;
        bus.btnC = 1'b1;
        tick(10);
        bus.btnC = 1'b0;
        tick(12);
        ex_x = HX;
        ex_y = HY;
        checks++;
        if (bus.active !== 1'b1 || bus.pos_x !== 7'd45 || bus.pos_y !== 6'd55) begin
            errors++;
            $display("FAIL home_reload: got active=%0b pos=(%0d,%0d), required 1 (45,55)", bus.active, bus.pos_x, bus.pos_y);
        end
        c5 = cyc;
        for (int k = 0; k < 15; k++) begin
            ex_x = mnext(ex_x, 1, XL);
            push_ev(ex_x, ex_y, c5 + 7 + PN * k);
        end
        bus.btnL = 1'b1;
        tick(148);
        bus.btnL = 1'b0;
        tick(16);
        c5 = cyc;
        for (int k = 0; k < 25; k++) begin
            ex_y = mnext(ex_y, -1, YL);
            push_ev(ex_x, ex_y, c5 + 7 + PN * k);
        end
        bus.btnD = 1'b1;
        tick(250);
        checks++;
        if (exp_q.size() != 0 || bus.pos_x !== 7'd60 || bus.pos_y !== 6'd30) begin
            errors++;
            $display("FAIL reach_60_30: got (%0d,%0d) with %0d steps missing, required (60,30) with 0",
                     bus.pos_x, bus.pos_y, exp_q.size());
        end
        #2 RESET_N = 1'b0;
        #1;
        checks++;
        if (bus.active !== 1'b0 || bus.pos_x !== 7'd45 || bus.pos_y !== 6'd55 || bus.step !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got active=%0b pos=(%0d,%0d) step=%0b, required 0 (45,55) 0",
                     bus.active, bus.pos_x, bus.pos_y, bus.step);
        end
        tick(2);
        RESET_N = 1'b1;
        tick(30);
        checks++;
        if (bus.active !== 1'b0 || bus.pos_x !== 7'd45 || bus.pos_y !== 6'd55) begin
            errors++;
            $display("FAIL idle_after_reset: got active=%0b pos=(%0d,%0d), required 0 (45,55)",
                     bus.active, bus.pos_x, bus.pos_y);
        end
        bus.btnD = 1'b0;
        tick(12);
        bus.btnC = 1'b1;
        tick(10);
        bus.btnC = 1'b0;
        tick(2);
        checks++;
        if (bus.active !== 1'b1 || bus.pos_x !== 7'd45 || bus.pos_y !== 6'd55) begin
            errors++;
            $display("FAIL restart: got active=%0b pos=(%0d,%0d), required 1 (45,55)", bus.active, bus.pos_x, bus.pos_y);
        end
        tick(12);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drained: got %0d pending steps, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_start_and_left();
        test_clamp_down();
        test_priority();
        test_bounce();
        test_home_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
